// File: rtl/lfsr_gen_if.sv
// Control and observation bundle for lfsr_gen: step/load controls in, state and
// period measurement out.
interface lfsr_gen_if #(
    parameter int WIDTH = 5
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             mode_gal;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] state_out;
    logic             bit_out;
    logic             valid;
    logic             period_done;
    logic [WIDTH-1:0] period_len;
    logic             lockup;

    modport master (
        output en, load, seed_in, mode_gal, sel,
        input  state_out, bit_out, valid, period_done, period_len, lockup
    );

    modport slave (
        input  en, load, seed_in, mode_gal, sel,
        output state_out, bit_out, valid, period_done, period_len, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Run-time configurable Fibonacci/Galois LFSR with seed load, zero-seed
// recovery, selectable serial tap and on-line period measurement.
//
// state | meaning
// IDLE  | out of reset, no load or step seen yet; valid low
// RUN   | sequence live; valid high until reset
module lfsr_gen #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] FIB_TAPS = 5'b10100,
    parameter logic [WIDTH-1:0] GAL_POLY = 5'b01001,
    parameter logic [WIDTH-1:0] SEED     = 5'b00001
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_gen_if.slave   bus
);
    localparam int SEL_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] plen_q;
    logic             pd_q;
    logic             lock_q;

    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] load_val;
    logic             seed_ok;
    logic             bit_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (bus.load || bus.en) fsm_d = RUN;
            RUN:     fsm_d = RUN;
            default: fsm_d = IDLE;
        endcase
    end

    assign fib_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & FIB_TAPS)};
    assign gal_next  = {lfsr_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr_q[WIDTH-1]}} & GAL_POLY);
    assign step_next = bus.mode_gal ? gal_next : fib_next;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
    assign seed_ok   = |bus.seed_in;
    // A zero seed would lock the register; substitute the reset seed instead.
    assign load_val  = seed_ok ? bus.seed_in : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
            ref_q  <= SEED;
            cnt_q  <= '0;
            plen_q <= '0;
            pd_q   <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            pd_q   <= 1'b0;
            lock_q <= 1'b0;
            if (bus.load) begin
                lfsr_q <= load_val;
                ref_q  <= load_val;
                cnt_q  <= '0;
                lock_q <= ~seed_ok;
            end else if (bus.en) begin
                lfsr_q <= step_next;
                if (step_next == ref_q) begin
                    plen_q <= cnt_inc;
                    cnt_q  <= '0;
                    pd_q   <= 1'b1;
                end else begin
                    cnt_q  <= cnt_inc;
                end
            end
        end
    end

    // Out-of-range selects match no index and fall back to bit 0.
    always_comb begin
        bit_sel = lfsr_q[0];
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.sel == i[SEL_W-1:0]) bit_sel = lfsr_q[i];
        end
    end

    assign bus.state_out   = lfsr_q;
    assign bus.bit_out     = bit_sel;
    assign bus.valid       = (fsm_q == RUN);
    assign bus.period_done = pd_q;
    assign bus.period_len  = plen_q;
    assign bus.lockup      = lock_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: arithmetic reference model checked every
// cycle plus hand-computed sequence and period expectations.
module tb_lfsr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lfsr_gen_if #(.WIDTH(5)) bus ();

    lfsr_gen #(
        .WIDTH(5), .FIB_TAPS(5'b10100), .GAL_POLY(5'b01001), .SEED(5'b00001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sequence values as integers, polynomial arithmetic.
    int m_state, m_ref, m_cnt, m_plen;
    bit m_valid, m_pd, m_lock;

    function automatic int fib_model(input int s);
        int fb;
        fb = $countones(5'(s) & 5'b10100) % 2;
        return ((s * 2) % 32) + fb;
    endfunction

    // Multiply by x modulo x^5 + x^3 + 1 (0b101001 = 41).
    function automatic int gal_model(input int s);
        int n;
        n = s * 2;
        if (n >= 32) n = n ^ 41;
        return n;
    endfunction

    task automatic model_reset();
        m_state = 1; m_ref = 1; m_cnt = 0; m_plen = 0;
        m_valid = 0; m_pd = 0; m_lock = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic cyc(input bit e, input bit l, input int sd, input bit g);
        int nxt;
        bus.en = e; bus.load = l; bus.seed_in = 5'(sd); bus.mode_gal = g;
        @(posedge clk);
        m_pd = 0; m_lock = 0;
        if (l) begin
            if (sd == 0) begin m_state = 1; m_lock = 1; end
            else         m_state = sd;
            m_ref = m_state; m_cnt = 0; m_valid = 1;
        end else if (e) begin
            nxt = g ? gal_model(m_state) : fib_model(m_state);
            m_valid = 1;
            if (nxt == m_ref) begin
                m_plen = (m_cnt + 1 > 31) ? 31 : m_cnt + 1;
                m_cnt = 0; m_pd = 1;
            end else if (m_cnt < 31) m_cnt++;
            m_state = nxt;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("state_out", bus.state_out, 32'(m_state));
        chk("valid", bus.valid, 32'(m_valid));
        chk("period_done", bus.period_done, 32'(m_pd));
        chk("period_len", bus.period_len, 32'(m_plen));
        chk("lockup", bus.lockup, 32'(m_lock));
        chk("bit_out", bus.bit_out,
            (bus.sel < 5) ? 32'((m_state >> bus.sel) & 1) : 32'(m_state & 1));
    end

    logic [4:0] fib_exp [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    logic [4:0] gal_exp [8] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
                                5'b10000, 5'b01001, 5'b10010, 5'b01101};

    initial begin
        bus.en = 0; bus.load = 0; bus.seed_in = 0; bus.mode_gal = 0; bus.sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fibonacci from reset
        chk("fib_seq0", bus.state_out, 32'(fib_exp[0]));
        chk("idle_valid", bus.valid, 0);
        for (int k = 1; k <= 31; k++) begin
            cyc(1, 0, 0, 0);
            if (k <= 5) chk("fib_seq", bus.state_out, 32'(fib_exp[k]));
            if (k == 30) chk("fib_pd_early", bus.period_done, 0);
        end
        chk("fib_pd", bus.period_done, 1);
        chk("fib_plen", bus.period_len, 31);
        chk("fib_wrap", bus.state_out, 1);

        // Galois from reset
        do_reset();
        chk("gal_seq0", bus.state_out, 32'(gal_exp[0]));
        for (int k = 1; k <= 31; k++) begin
            cyc(1, 0, 0, 1);
            if (k <= 7) chk("gal_seq", bus.state_out, 32'(gal_exp[k]));
        end
        chk("gal_pd", bus.period_done, 1);
        chk("gal_plen", bus.period_len, 31);

        // Seed load then full period back to the loaded seed
        cyc(0, 1, 5'b10110, 0);
        chk("load_state", bus.state_out, 32'h16);
        for (int k = 1; k <= 31; k++) cyc(1, 0, 0, 0);
        chk("load_pd", bus.period_done, 1);
        chk("load_wrap", bus.state_out, 32'h16);

        // Zero seed recovery, lockup for exactly one cycle; load beats en
        cyc(1, 1, 0, 0);
        chk("zero_load_state", bus.state_out, 1);
        chk("lockup_hi", bus.lockup, 1);
        cyc(0, 0, 0, 0);
        chk("lockup_lo", bus.lockup, 0);
        cyc(1, 1, 5'b00111, 0);
        chk("load_over_en", bus.state_out, 32'h07);

        // Select sweep with mode switching mid-sequence
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            cyc(1, 0, 0, s[0]);
            cyc(1, 0, 0, 0);
        end
        bus.sel = 3'd7;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_state", bus.state_out, 1);
        chk("async_valid", bus.valid, 0);
        chk("async_plen", bus.period_len, 0);
        #3 rst = 1'b0;

        // Run into a period end, then hold with en low
        for (int k = 1; k <= 31; k++) cyc(1, 0, 0, 0);
        chk("hold_pd_start", bus.period_done, 1);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 0);
            chk("hold_state", bus.state_out, 1);
            chk("hold_pd", bus.period_done, 0);
        end
        cyc(1, 0, 0, 0);
        chk("resume_step", bus.state_out, 2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
